mem_responder: RTL and testbench

//  Responder end of the on-chip memory port: accepts read/write requests on a valid/ready

---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_responder_fifo2.sv | 61 ++++++
 rtl/mem_responder.sv | 61 ++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the on-chip memory port: response encoding, default widths and the
// width of one response FIFO entry.
package mem_if_pkg;

  localparam logic RSP_WRITE = 1'b1;
  localparam logic RSP_READ  = 1'b0;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // One response entry is {write flag, data word}.
  function automatic int unsigned rsp_entry_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/mem_responder_fifo2.sv
// Two-entry response FIFO with 1-bit wrapping pointers and a separate occupancy count.
// The caller only pushes when there is room (or a pop frees it) and only pops when non-empty.
module mem_responder_fifo2
  import mem_if_pkg::*;
#(
  parameter int unsigned DataW = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             push_write_i,
  input  logic [DataW-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             head_write_o,
  output logic [DataW-1:0] head_data_o
);

  localparam int unsigned EntryW = rsp_entry_w(DataW);

  logic [EntryW-1:0] entry_q [2];
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Push+pop when full overwrites the slot being popped; the head has already been consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i) begin
        entry_q[wr_ptr_q] <= {push_write_i, push_data_i};
      end
    end
  end

  assign count_o                     = count_q;
  assign {head_write_o, head_data_o} = entry_q[rd_ptr_q];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the on-chip memory port: valid/ready requests serviced from an internal RAM,
// one in-order response per request returned through a 2-entry FIFO.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W,
  parameter int unsigned DataW = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [DataW-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_write_o,
  output logic [DataW-1:0] rsp_rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [1:0]       count;
  logic             req_fire;
  logic             rsp_fire;
  logic [DataW-1:0] push_data;
  logic             push_write;

  // A pop this cycle frees a slot, so a full FIFO can still accept.
  assign req_ready_o = (count != 2'd2) | rsp_ready_i;
  assign req_fire    = req_valid_i & req_ready_o;
  assign rsp_valid_o = (count != 2'd0);
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;

  assign push_write = req_write_i ? RSP_WRITE : RSP_READ;
  assign push_data  = req_write_i ? '0 : mem_q[req_addr_i];

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (req_fire && req_write_i) begin
      mem_q[req_addr_i] <= req_wdata_i;
    end
  end

  mem_responder_fifo2 #(
    .DataW(DataW)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (req_fire),
    .push_write_i (push_write),
    .push_data_i  (push_data),
    .pop_i        (rsp_fire),
    .count_o      (count),
    .head_write_o (rsp_write_o),
    .head_data_o  (rsp_rdata_o)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed vectors plus a randomised handshake phase.
module tb_mem_responder;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem_m [256];
  int          total;
  int          bad;

  mem_responder u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write),
    .rsp_rdata_o (rsp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_rsp(input logic w, input logic [31:0] d);
    exp_t e;
    e.w = w;
    e.d = w ? 32'd0 : d;
    sb.push_back(e);
  endtask

  // Monitor: every response the DUT hands over must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_rsp: got write=%b data=%h want no response", rsp_write, rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_write", {31'd0, rsp_write}, {31'd0, mon_e.w});
        check("rsp_rdata", rsp_rdata, mon_e.d);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic req(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d);
    bit accepted;
    accepted  = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        expect_rsp(w, exp_d);
        if (w) mem_m[a] = d;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got no accept want accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    #3;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_write", {31'd0, rsp_write}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // 1: back-to-back writes
    req(1'b1, 8'd5, 32'd100, 32'd0);
    check("t1_latency", {31'd0, rsp_valid}, 32'd1);
    check("t1_req_ready", {31'd0, req_ready}, 32'd1);
    req(1'b1, 8'd6, 32'd101, 32'd0);
    check("t1_req_ready2", {31'd0, req_ready}, 32'd1);

    // 2: reads return the written data with 1-cycle latency
    req(1'b0, 8'd5, 32'd0, 32'd100);
    check("t2_latency_a", {31'd0, rsp_valid}, 32'd1);
    check("t2_data_a", rsp_rdata, 32'd100);
    req(1'b0, 8'd6, 32'd0, 32'd101);
    check("t2_latency_b", {31'd0, rsp_valid}, 32'd1);
    check("t2_data_b", rsp_rdata, 32'd101);
    idle(2);

    // 3: backpressure with a full FIFO
    rsp_ready = 1'b0;
    req(1'b0, 8'd5, 32'd0, 32'd100);
    req(1'b0, 8'd6, 32'd0, 32'd101);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'd6;
    @(negedge clk);
    check("t3_full_ready", {31'd0, req_ready}, 32'd0);
    check("t3_held_valid", {31'd0, rsp_valid}, 32'd1);
    check("t3_held_data", rsp_rdata, 32'd100);
    idle(1);
    @(negedge clk);
    check("t3_still_full", {31'd0, req_ready}, 32'd0);
    check("t3_stable_data", rsp_rdata, 32'd100);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_pass_through", {31'd0, req_ready}, 32'd1);
    if (req_ready) expect_rsp(1'b0, 32'd101);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    idle(3);

    // 4: write then read the same address on consecutive accepts
    req(1'b1, 8'd7, 32'hDEADBEEF, 32'd0);
    req(1'b0, 8'd7, 32'd0, 32'hDEADBEEF);
    idle(2);

    // 5: asynchronous reset with two responses pending
    rsp_ready = 1'b0;
    req(1'b0, 8'd5, 32'd0, 32'd100);
    req(1'b0, 8'd6, 32'd0, 32'd101);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_rst_rdata", rsp_rdata, 32'd0);
    check("t5_rst_write", {31'd0, rsp_write}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_release_ready", {31'd0, req_ready}, 32'd1);
    check("t5_release_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    req(1'b0, 8'd5, 32'd0, 32'd100);
    idle(2);

    // 6: random traffic over the already-written addresses 5..7
    for (int c = 0; c < 1000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = 8'(5 + $urandom_range(0, 2));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (req_valid && req_ready) begin
        expect_rsp(req_write, mem_m[req_addr]);
        if (req_write) mem_m[req_addr] = req_wdata;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check("drain_pending", sb.size(), 32'd0);
    @(negedge clk);
    check("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
